// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states,
// requester ids and the size/alignment check used when a request is accepted.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_MERGE_WR = 2'b10,
        ST_RESP     = 2'b11
    } state_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic size_align_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant while enabled, pointer remembers
// the last granted requester and advances only on an actual grant.
module dmem_rr_arb
    import dmem_pkg::*;
(
    input  logic       clkin,
    input  logic       nrst_in,
    input  logic [1:0] req,
    input  logic       gnt_en,
    output logic [1:0] gnt
);

    logic last_r;

    // Grant selection: a tie goes to the requester not granted last.
    always_comb begin
        gnt = 2'b00;
        if (!gnt_en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = (last_r == REQ_ID1) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Last-granted pointer; reset value lets port 0 win the first tie.
    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            last_r <= REQ_ID1;
        end else if (gnt_en && (req != 2'b00)) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Shares the word-wide data memory between the core LSU (port 0) and the debug
// loader (port 1); byte/half loads extract a lane, byte/half stores read-modify-write.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clkin,
    input  logic        nrst_in,
    input  logic        r0_req_in,
    input  logic        r0_we_in,
    input  logic [1:0]  r0_size_in,
    input  logic [31:0] r0_addr_in,
    input  logic [31:0] r0_wdata_in,
    output logic        r0_gnt_out,
    output logic        r0_rvalid_out,
    output logic [31:0] r0_rdata_out,
    output logic        r0_err_out,
    input  logic        r1_req_in,
    input  logic        r1_we_in,
    input  logic [1:0]  r1_size_in,
    input  logic [31:0] r1_addr_in,
    input  logic [31:0] r1_wdata_in,
    output logic        r1_gnt_out,
    output logic        r1_rvalid_out,
    output logic [31:0] r1_rdata_out,
    output logic        r1_err_out,
    output logic        mem_wr_en_out,
    output logic [31:0] mem_wr_idx_out,
    output logic [31:0] mem_wr_data_out,
    output logic [31:0] mem_rd_idx_out,
    input  logic [31:0] mem_rd_data_in
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_r, state_nxt_s;
    logic [1:0]  req_s, arb_gnt_s;
    logic        arb_en_s, accept_s;
    logic        sel_we_s, sel_err_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_addr_s, sel_wdata_s, sel_idx_s;
    logic        owner_r, we_r, err_r;
    logic [1:0]  size_r, lane_r;
    logic [29:0] idx_r;
    logic [31:0] wdata_r, hold_r, rdata_r;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        logic [31:0] sh_b, sh_h, res;
        sh_b = word >> {addr_lo, 3'b000};
        sh_h = word >> {addr_lo[1], 4'b0000};
        case (size)
            SZ_BYTE: res = {24'h00_0000, sh_b[7:0]};
            SZ_HALF: res = {16'h0000, sh_h[15:0]};
            SZ_WORD: res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane(s); every other byte keeps the old value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_d,
                                               input logic [1:0] size, input logic [1:0] addr_lo);
        logic [31:0] mask;
        logic [4:0]  sh;
        case (size)
            SZ_BYTE: begin
                sh   = {addr_lo, 3'b000};
                mask = 32'h0000_00FF << sh;
            end
            SZ_HALF: begin
                sh   = {addr_lo[1], 4'b0000};
                mask = 32'h0000_FFFF << sh;
            end
            default: begin
                sh   = 5'd0;
                mask = 32'h0000_0000;
            end
        endcase
        return (old_w & ~mask) | ((new_d << sh) & mask);
    endfunction

    assign req_s    = {r1_req_in, r0_req_in};
    assign arb_en_s = (state_r == ST_IDLE);
    assign accept_s = arb_en_s && (req_s != 2'b00);

    dmem_rr_arb u_arb (
        .clkin   (clkin),
        .nrst_in (nrst_in),
        .req     (req_s),
        .gnt_en  (arb_en_s),
        .gnt     (arb_gnt_s)
    );

    // Winner's request fields and error classification.
    always_comb begin
        sel_we_s    = r0_we_in;
        sel_size_s  = r0_size_in;
        sel_addr_s  = r0_addr_in;
        sel_wdata_s = r0_wdata_in;
        if (arb_gnt_s[1]) begin
            sel_we_s    = r1_we_in;
            sel_size_s  = r1_size_in;
            sel_addr_s  = r1_addr_in;
            sel_wdata_s = r1_wdata_in;
        end else begin
            sel_we_s    = r0_we_in;
            sel_size_s  = r0_size_in;
            sel_addr_s  = r0_addr_in;
            sel_wdata_s = r0_wdata_in;
        end
        sel_idx_s = {2'b00, sel_addr_s[31:2]};
        sel_err_s = size_align_err(sel_size_s, sel_addr_s[1:0]) || (sel_idx_s >= DEPTH_W);
    end

    // State register.
    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!err_r && we_r && (size_r != SZ_WORD)) begin
                    state_nxt_s = ST_MERGE_WR;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_MERGE_WR: state_nxt_s = ST_RESP;
            ST_RESP:     state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Transaction fields latched at acceptance.
    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            owner_r <= REQ_ID0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= SZ_BYTE;
            lane_r  <= 2'b00;
            idx_r   <= 30'd0;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            owner_r <= arb_gnt_s[1];
            we_r    <= sel_we_s;
            err_r   <= sel_err_s;
            size_r  <= sel_size_s;
            lane_r  <= sel_addr_s[1:0];
            idx_r   <= sel_addr_s[31:2];
            wdata_r <= sel_wdata_s;
        end else begin
            owner_r <= owner_r;
            we_r    <= we_r;
            err_r   <= err_r;
            size_r  <= size_r;
            lane_r  <= lane_r;
            idx_r   <= idx_r;
            wdata_r <= wdata_r;
        end
    end

    // Load result and read-modify-write holding word, both captured in ACCESS.
    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            rdata_r <= 32'h0000_0000;
            hold_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            rdata_r <= 32'h0000_0000;
            hold_r  <= hold_r;
        end else if ((state_r == ST_ACCESS) && !err_r) begin
            rdata_r <= we_r ? 32'h0000_0000 : lane_extract(mem_rd_data_in, size_r, lane_r);
            hold_r  <= mem_rd_data_in;
        end else begin
            rdata_r <= rdata_r;
            hold_r  <= hold_r;
        end
    end

    // Outputs decoded from state and latched fields only.
    always_comb begin
        r0_gnt_out      = 1'b0;
        r1_gnt_out      = 1'b0;
        r0_rvalid_out   = 1'b0;
        r1_rvalid_out   = 1'b0;
        r0_rdata_out    = 32'h0000_0000;
        r1_rdata_out    = 32'h0000_0000;
        r0_err_out      = 1'b0;
        r1_err_out      = 1'b0;
        mem_wr_en_out   = 1'b0;
        mem_wr_idx_out  = 32'h0000_0000;
        mem_wr_data_out = 32'h0000_0000;
        mem_rd_idx_out  = 32'h0000_0000;
        case (state_r)
            ST_ACCESS: begin
                if (owner_r == REQ_ID1) begin
                    r1_gnt_out = 1'b1;
                end else begin
                    r0_gnt_out = 1'b1;
                end
                if (err_r) begin
                    mem_wr_en_out = 1'b0;
                end else if (we_r && (size_r == SZ_WORD)) begin
                    mem_wr_en_out   = 1'b1;
                    mem_wr_idx_out  = {2'b00, idx_r};
                    mem_wr_data_out = wdata_r;
                end else begin
                    mem_rd_idx_out = {2'b00, idx_r};
                end
            end
            ST_MERGE_WR: begin
                mem_wr_en_out   = 1'b1;
                mem_wr_idx_out  = {2'b00, idx_r};
                mem_wr_data_out = lane_merge(hold_r, wdata_r, size_r, lane_r);
            end
            ST_RESP: begin
                if (owner_r == REQ_ID1) begin
                    r1_rvalid_out = 1'b1;
                    r1_rdata_out  = rdata_r;
                    r1_err_out    = err_r;
                end else begin
                    r0_rvalid_out = 1'b1;
                    r0_rdata_out  = rdata_r;
                    r0_err_out    = err_r;
                end
            end
            default: begin
                mem_wr_en_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural data memory and a response
// scoreboard: expectations are queued at issue and checked at rvalid.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clkin, nrst_in;
    logic        r0_req_in, r0_we_in, r1_req_in, r1_we_in;
    logic [1:0]  r0_size_in, r1_size_in;
    logic [31:0] r0_addr_in, r0_wdata_in, r1_addr_in, r1_wdata_in;
    logic        r0_gnt_out, r0_rvalid_out, r0_err_out;
    logic        r1_gnt_out, r1_rvalid_out, r1_err_out;
    logic [31:0] r0_rdata_out, r1_rdata_out;
    logic        mem_wr_en_out;
    logic [31:0] mem_wr_idx_out, mem_wr_data_out, mem_rd_idx_out, mem_rd_data_in;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] mem [0:255];

    dmem_ctrl #(.DEPTH(256)) dut (
        .clkin(clkin), .nrst_in(nrst_in),
        .r0_req_in(r0_req_in), .r0_we_in(r0_we_in), .r0_size_in(r0_size_in),
        .r0_addr_in(r0_addr_in), .r0_wdata_in(r0_wdata_in),
        .r0_gnt_out(r0_gnt_out), .r0_rvalid_out(r0_rvalid_out),
        .r0_rdata_out(r0_rdata_out), .r0_err_out(r0_err_out),
        .r1_req_in(r1_req_in), .r1_we_in(r1_we_in), .r1_size_in(r1_size_in),
        .r1_addr_in(r1_addr_in), .r1_wdata_in(r1_wdata_in),
        .r1_gnt_out(r1_gnt_out), .r1_rvalid_out(r1_rvalid_out),
        .r1_rdata_out(r1_rdata_out), .r1_err_out(r1_err_out),
        .mem_wr_en_out(mem_wr_en_out), .mem_wr_idx_out(mem_wr_idx_out),
        .mem_wr_data_out(mem_wr_data_out), .mem_rd_idx_out(mem_rd_idx_out),
        .mem_rd_data_in(mem_rd_data_in)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    // Data memory: synchronous write, combinational read; not touched by reset.
    always @(posedge clkin) begin
        if (mem_wr_en_out) begin
            mem[mem_wr_idx_out[7:0]] <= mem_wr_data_out;
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign mem_rd_data_in = mem[mem_rd_idx_out[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grants and responses must never be given to both ports at once.
    always @(negedge clkin) begin
        if (nrst_in) begin
            chk("gnt_onehot", {31'd0, r0_gnt_out & r1_gnt_out}, 32'd0);
            chk("rvalid_onehot", {31'd0, r0_rvalid_out & r1_rvalid_out}, 32'd0);
        end
    end

    task automatic push(input int port, input logic [31:0] rdata, input logic err);
        sb_t e;
        e.port = port;
        e.rdata = rdata;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            r0_req_in = req; r0_we_in = we; r0_size_in = size; r0_addr_in = addr; r0_wdata_in = wdata;
        end else begin
            r1_req_in = req; r1_we_in = we; r1_size_in = size; r1_addr_in = addr; r1_wdata_in = wdata;
        end
    endtask

    task automatic pop_check(input string tag);
        sb_t e;
        int  p;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            p = r1_rvalid_out ? 1 : 0;
            chk({tag, "_port"}, 32'(p), 32'(e.port));
            chk({tag, "_rdata"}, (p == 1) ? r1_rdata_out : r0_rdata_out, e.rdata);
            chk({tag, "_err"}, {31'd0, (p == 1) ? r1_err_out : r0_err_out}, {31'd0, e.err});
        end
    endtask

    task automatic wait_gnt(input int port, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clkin); #1;
            got = (port == 1) ? r1_gnt_out : r0_gnt_out;
        end
        chk({tag, "_gnt"}, 32'(got), 32'd1);
    endtask

    task automatic wait_rv(input string tag, output int cyc);
        bit got = 1'b0;
        cyc = 0;
        while (!got && cyc < 12) begin
            @(posedge clkin); #1;
            cyc++;
            got = r0_rvalid_out | r1_rvalid_out;
        end
        chk({tag, "_rvalid"}, 32'(got), 32'd1);
        if (got) pop_check(tag);
    endtask

    // Latency is counted from the edge that samples req to the edge that samples rvalid.
    task automatic run_txn(input string tag, input int port, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input int exp_wr);
        int cyc, wr0;
        push(port, exp_rd, exp_err);
        wr0 = wr_cnt;
        @(negedge clkin);
        drive(port, 1'b1, we, size, addr, wdata);
        wait_gnt(port, tag);
        drive(port, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        wait_rv(tag, cyc);
        chk({tag, "_lat"}, 32'(cyc + 1), 32'(exp_lat));
        chk({tag, "_wrs"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        int cyc, wr0;
        nrst_in = 1'b0;
        drive(0, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        repeat (3) @(posedge clkin);
        #1;
        chk("rst_ctrl", {26'd0, r0_gnt_out, r0_rvalid_out, r0_err_out, r1_gnt_out, r1_rvalid_out,
                         r1_err_out}, 32'd0);
        chk("rst_rdata0", r0_rdata_out, 32'd0);
        chk("rst_rdata1", r1_rdata_out, 32'd0);
        chk("rst_mem", {31'd0, mem_wr_en_out} | mem_wr_idx_out | mem_wr_data_out | mem_rd_idx_out,
            32'd0);
        @(negedge clkin);
        nrst_in = 1'b1;

        // Word store / load, then lane stores over it (lane 1 of 0xDEADBEEF is 0xBE).
        run_txn("st_w10", 0, 1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        chk("mem_w10", mem[4], 32'hDEADBEEF);
        run_txn("ld_w10", 0, 1'b0, SZ_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
        run_txn("st_b11", 0, 1'b1, SZ_BYTE, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3, 1);
        chk("mem_b11", mem[4], 32'hDEADAAEF);
        run_txn("ld_b11", 1, 1'b0, SZ_BYTE, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        run_txn("st_h12", 0, 1'b1, SZ_HALF, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3, 1);
        chk("mem_h12", mem[4], 32'h1234AAEF);
        run_txn("ld_h12", 1, 1'b0, SZ_HALF, 32'h12, 32'h0, 32'h00001234, 1'b0, 2, 0);
        run_txn("ld_b13", 0, 1'b0, SZ_BYTE, 32'h13, 32'h0, 32'h00000012, 1'b0, 2, 0);
        run_txn("ld_h10", 1, 1'b0, SZ_HALF, 32'h10, 32'h0, 32'h0000AAEF, 1'b0, 2, 0);
        run_txn("st_w20", 0, 1'b1, SZ_WORD, 32'h20, 32'h11111111, 32'h0, 1'b0, 2, 1);
        run_txn("st_w24", 1, 1'b1, SZ_WORD, 32'h24, 32'h22222222, 32'h0, 1'b0, 2, 1);

        // Both ports request continuously; port 1 was granted last, so 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            push(k % 2, (k % 2 == 0) ? 32'h11111111 : 32'h22222222, 1'b0);
        end
        wr0 = wr_cnt;
        @(negedge clkin);
        drive(0, 1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_WORD, 32'h24, 32'h0);
        for (int k = 0; k < 6; k++) begin
            wait_rv("arb", cyc);
        end
        drive(0, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        chk("arb_wrs", 32'(wr_cnt - wr0), 32'd0);

        // Error cases: no memory write, rdata 0.
        run_txn("e_h13", 0, 1'b0, SZ_HALF, 32'h13, 32'h0, 32'h0, 1'b1, 2, 0);
        run_txn("e_w02", 1, 1'b0, SZ_WORD, 32'h02, 32'h0, 32'h0, 1'b1, 2, 0);
        run_txn("e_sz11", 0, 1'b0, SZ_ILL, 32'h00, 32'h0, 32'h0, 1'b1, 2, 0);
        run_txn("e_ld400", 1, 1'b0, SZ_WORD, 32'h400, 32'h0, 32'h0, 1'b1, 2, 0);
        run_txn("e_stw400", 0, 1'b1, SZ_WORD, 32'h400, 32'h5A5A5A5A, 32'h0, 1'b1, 2, 0);
        run_txn("e_stb401", 1, 1'b1, SZ_BYTE, 32'h401, 32'h55, 32'h0, 1'b1, 2, 0);
        run_txn("e_sth11", 0, 1'b1, SZ_HALF, 32'h11, 32'hBEEF, 32'h0, 1'b1, 2, 0);
        chk("mem_after_err", mem[4], 32'h1234AAEF);

        // Reset during MERGE_WR aborts the store before it lands.
        @(negedge clkin);
        drive(0, 1'b1, 1'b1, SZ_BYTE, 32'h10, 32'h55);
        wait_gnt(0, "rst_st");
        drive(0, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        @(posedge clkin); #1;
        chk("rst_merge_en", {31'd0, mem_wr_en_out}, 32'd1);
        chk("rst_merge_data", mem_wr_data_out, 32'h1234AA55);
        wr0 = wr_cnt;
        nrst_in = 1'b0;
        #1;
        chk("rst_abort_ctrl", {27'd0, mem_wr_en_out, r0_gnt_out, r0_rvalid_out, r1_gnt_out,
                               r1_rvalid_out}, 32'd0);
        chk("rst_abort_wdata", mem_wr_data_out | mem_wr_idx_out | r0_rdata_out, 32'd0);
        repeat (2) @(negedge clkin);
        nrst_in = 1'b1;
        chk("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_mem_kept", mem[4], 32'h1234AAEF);

        // First tie after reset goes to port 0, then port 1.
        push(0, 32'h1234AAEF, 1'b0);
        push(1, 32'h00000034, 1'b0);
        @(negedge clkin);
        drive(0, 1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_BYTE, 32'h12, 32'h0);
        wait_gnt(0, "post_rst0");
        chk("post_rst_gnt1", {31'd0, r1_gnt_out}, 32'd0);
        drive(0, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        wait_rv("post_rst0", cyc);
        wait_gnt(1, "post_rst1");
        drive(1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        wait_rv("post_rst1", cyc);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(posedge clkin);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
